// File: rtl/mac_frame_accum.sv
// Pipelined multiply-accumulate: registers operands, multiplies, then sums
// LEN products per frame with wrap or saturate overflow and a per-frame flag.
module mac_frame_accum #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 12,
  parameter int LEN       = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr,
  output logic [ACC_WIDTH-1:0] d,
  output logic                 out_valid,
  output logic                 ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [WIDTH-1:0]     r1_q, r1_d, r2_q, r2_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 fo_q, fo_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic                 ov_q, ov_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic                 term_ovf;
  logic [ACC_WIDTH-1:0] result;
  logic                 fo_next;

  // First term of a frame ignores the previous accumulator and sticky flag.
  always_comb begin
    base     = (cnt_q == '0) ? '0 : acc_q;
    sum      = {1'b0, base} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, p_q};
    term_ovf = sum[ACC_WIDTH];
    result   = ((SATURATE != 0) && term_ovf) ? '1 : sum[ACC_WIDTH-1:0];
    fo_next  = ((cnt_q == '0) ? 1'b0 : fo_q) | term_ovf;
  end

  always_comb begin
    r1_d  = r1_q;
    r2_d  = r2_q;
    v1_d  = in_valid;
    p_d   = p_q;
    v2_d  = v1_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    fo_d  = fo_q;
    res_d = res_q;
    ov_d  = 1'b0;
    ovf_d = ovf_q;

    if (in_valid) begin
      r1_d = a;
      r2_d = b;
    end
    if (v1_q) begin
      p_d = {{WIDTH{1'b0}}, r1_q} * {{WIDTH{1'b0}}, r2_q};
    end

    if (v2_q) begin
      if (cnt_q == LAST) begin
        res_d = result;
        ovf_d = fo_next;
        ov_d  = 1'b1;
        cnt_d = '0;
        acc_d = '0;
        fo_d  = 1'b0;
      end else begin
        acc_d = result;
        fo_d  = fo_next;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Abort wins over everything, including a frame completing this cycle.
    if (clr) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      cnt_d = '0;
      acc_d = '0;
      fo_d  = 1'b0;
      ov_d  = 1'b0;
      res_d = res_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q  <= '0;
      r2_q  <= '0;
      v1_q  <= 1'b0;
      p_q   <= '0;
      v2_q  <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      fo_q  <= 1'b0;
      res_q <= '0;
      ov_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      v1_q  <= v1_d;
      p_q   <= p_d;
      v2_q  <= v2_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      fo_q  <= fo_d;
      res_q <= res_d;
      ov_q  <= ov_d;
      ovf_q <= ovf_d;
    end
  end

  assign d         = res_q;
  assign out_valid = ov_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_frame_accum.sv
// Bench for mac_frame_accum: four parameter sets share one stimulus stream and
// are compared each cycle against a frame-level arithmetic model.
module tb_mac_frame_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       clr = 1'b0;

  logic [11:0] d_def, d_l1;
  logic [7:0]  d_w8, d_sat;
  logic        ov_def, ov_w8, ov_sat, ov_l1;
  logic        of_def, of_w8, of_sat, of_l1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_frame_accum #(.WIDTH(4), .ACC_WIDTH(12), .LEN(4), .SATURATE(0)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
    .d(d_def), .out_valid(ov_def), .ovf(of_def));
  mac_frame_accum #(.WIDTH(4), .ACC_WIDTH(8), .LEN(4), .SATURATE(0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
    .d(d_w8), .out_valid(ov_w8), .ovf(of_w8));
  mac_frame_accum #(.WIDTH(4), .ACC_WIDTH(8), .LEN(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
    .d(d_sat), .out_valid(ov_sat), .ovf(of_sat));
  mac_frame_accum #(.WIDTH(4), .ACC_WIDTH(12), .LEN(1), .SATURATE(0)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
    .d(d_l1), .out_valid(ov_l1), .ovf(of_l1));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: a pair accepted on edge k contributes on edge k+2; every LEN
  // contributions form a frame whose result is plain integer arithmetic.
  localparam int P_AW  [4] = '{12, 8, 8, 12};
  localparam int P_LEN [4] = '{4, 4, 4, 1};
  localparam int P_SAT [4] = '{0, 0, 1, 0};

  typedef struct { int land; int prod; } pend_t;
  pend_t pq[$];
  int    edge_n = 0;
  int    m_n[4], m_tot[4], m_d[4], m_ovf[4], m_pulse[4];

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < 4; i++) begin
      m_n[i] = 0; m_tot[i] = 0; m_d[i] = 0; m_ovf[i] = 0; m_pulse[i] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      edge_n++;
      for (int i = 0; i < 4; i++) m_pulse[i] = 0;
      if (clr) begin
        pq.delete();
        for (int i = 0; i < 4; i++) begin
          m_n[i] = 0; m_tot[i] = 0;
        end
      end else begin
        if (pq.size() > 0 && pq[0].land == edge_n) begin
          pend_t e;
          e = pq.pop_front();
          for (int i = 0; i < 4; i++) begin
            int lim;
            m_tot[i] += e.prod;
            m_n[i]++;
            if (m_n[i] == P_LEN[i]) begin
              lim      = 1 << P_AW[i];
              m_ovf[i] = (m_tot[i] >= lim) ? 1 : 0;
              if (P_SAT[i] != 0) m_d[i] = (m_tot[i] >= lim) ? lim - 1 : m_tot[i];
              else               m_d[i] = m_tot[i] % lim;
              m_pulse[i] = 1;
              m_n[i]     = 0;
              m_tot[i]   = 0;
            end
          end
        end
        if (in_valid) pq.push_back('{edge_n + 2, int'(a) * int'(b)});
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      int od[4], ov[4], of[4];
      od[0] = int'(d_def); od[1] = int'(d_w8); od[2] = int'(d_sat); od[3] = int'(d_l1);
      ov[0] = int'(ov_def); ov[1] = int'(ov_w8); ov[2] = int'(ov_sat); ov[3] = int'(ov_l1);
      of[0] = int'(of_def); of[1] = int'(of_w8); of[2] = int'(of_sat); of[3] = int'(of_l1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]@%0t", i, $time), ov[i], m_pulse[i]);
        chk($sformatf("d[%0d]@%0t", i, $time), od[i], m_d[i]);
        chk($sformatf("ovf[%0d]@%0t", i, $time), of[i], m_ovf[i]);
      end
    end
  end

  task automatic cyc(input bit v, input int av, input int bv, input bit c);
    in_valid = v;
    a        = 4'(av);
    b        = 4'(bv);
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #20 rst = 1'b0;
    chk("rst_d", int'(d_def), 0);
    chk("rst_ov", int'(ov_def), 0);
    chk("rst_ovf", int'(of_def), 0);
    idle(10);

    // Back-to-back frame of (1,2),(3,4),(5,6),(7,8)
    for (int i = 0; i < 4; i++) cyc(1'b1, 2*i + 1, 2*i + 2, 1'b0);
    idle(3);
    chk("t2_d", int'(d_def), 100);
    chk("t2_ovf", int'(of_def), 0);

    // Same frame with gaps, then two frames back to back
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2*i + 1, 2*i + 2, 1'b0);
      idle(2);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) cyc(1'b1, 2*i + 1, 2*i + 2, 1'b0);
    idle(3);
    chk("t3_d", int'(d_def), 100);

    // Overflow frame, then a small frame
    for (int i = 0; i < 4; i++) cyc(1'b1, 15, 15, 1'b0);
    idle(3);
    chk("t4_wrap_d", int'(d_w8), 132);
    chk("t4_wrap_ovf", int'(of_w8), 1);
    chk("t4_sat_d", int'(d_sat), 255);
    chk("t4_sat_ovf", int'(of_sat), 1);
    chk("t4_def_d", int'(d_def), 900);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1, 1'b0);
    idle(3);
    chk("t4b_wrap_d", int'(d_w8), 4);
    chk("t4b_wrap_ovf", int'(of_w8), 0);
    chk("t4b_sat_d", int'(d_sat), 4);
    chk("t4b_sat_ovf", int'(of_sat), 0);

    // Abort a partial frame with clr coincident with a third pair
    for (int i = 0; i < 4; i++) cyc(1'b1, 2, 3, 1'b0);
    idle(3);
    cyc(1'b1, 3, 3, 1'b0);
    cyc(1'b1, 3, 3, 1'b0);
    cyc(1'b1, 3, 3, 1'b1);
    idle(3);
    chk("t5_hold_d", int'(d_def), 24);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1, 1'b0);
    idle(3);
    chk("t5_d", int'(d_def), 4);

    // Asynchronous reset between edges in the middle of a frame
    cyc(1'b1, 2, 2, 1'b0);
    cyc(1'b1, 2, 2, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_d", int'(d_def), 0);
    chk("t6_rst_l1", int'(d_l1), 0);
    chk("t6_rst_ov", int'(ov_def), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 2, 2, 1'b0);
    idle(3);
    chk("t6_d", int'(d_def), 16);

    // Single-product frames
    cyc(1'b1, 3, 5, 1'b0);
    cyc(1'b1, 15, 15, 1'b0);
    idle(1);
    chk("t6_l1_ov_a", int'(ov_l1), 1);
    chk("t6_l1_d_a", int'(d_l1), 15);
    idle(1);
    chk("t6_l1_ov_b", int'(ov_l1), 1);
    chk("t6_l1_d_b", int'(d_l1), 225);
    idle(2);

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 29) == 0);
    idle(4);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
